mygo_fifo_ex: RTL
=================

# mygo_fifo_ex

Parametrised successor to the channel FIFO used by the backend to implement buffered Go channels between stage processes. Adds true directional ports, active-low asynchronous reset, synchronous flush, occupancy and threshold flags, and a high-water monitor. An optional same-cycle bypass path is available for latency-critical channels. Each channel FIFO instance sits between a producer stage and a consumer stage, and is instantiated through per-width/depth wrapper modules.

## Interface
- `WIDTH`, default 32: data bits per entry; must be ≥1.
- `DEPTH`, default 4: number of entries; must be ≥1. Non-power-of-two values are legal.
- `AFULL_LEVEL`, default `DEPTH-1`: `almost_full` asserts when `level` ≥ this value.
- `AEMPTY_LEVEL`, default 1: `almost_empty` asserts when `level` ≤ this value.
- `ADDR_BITS`, default `max(1, clog2(DEPTH))`: pointer width. Derived; do not override.
- `COUNT_BITS`, default `max(1, clog2(DEPTH+1))`: occupancy width. Derived; do not override.

Ports (clock and reset first):
- `clk`, input, 1: sole clock. All state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `flush`, input, 1: synchronous clear of all entries.
- `in_data`, input, `WIDTH`: write data.
- `in_valid`, input, 1: producer offers `in_data`.
- `in_ready`, output, 1: FIFO can accept a word.
- `out_data`, output, `WIDTH`: head-of-queue data.
- `out_valid`, output, 1: `out_data` is valid.
- `out_ready`, input, 1: consumer takes the word.
- `level`, output, `COUNT_BITS`: current occupancy, 0..`DEPTH`.
- `almost_full`, output, 1: threshold flag.
- `almost_empty`, output, 1: threshold flag.
- `high_water`, output, `COUNT_BITS`: maximum `level` seen since reset.

## Operation
- push = `in_valid & in_ready`.
- pop = `out_valid & out_ready`, counting only pops from storage.
- `in_ready` = (`level` < `DEPTH`). It is a function of state only and never depends combinationally on `out_ready`. A full FIFO therefore refuses a push even when a pop occurs in the same cycle.
- `out_valid` = (`level` ≠ 0), before the bypass term described under Configuration.
- `out_data` = `mem[rptr]` when `out_valid` is high, otherwise all zeros.
- Write pointer `wptr` and read pointer `rptr` increment on push and pop respectively. Each wraps from `DEPTH-1` to 0, including for non-power-of-two `DEPTH`.
- `level` next-state rules:
  - push only: +1
  - pop only: −1
  - push and pop together: unchanged, while both pointers advance.
- `flush` takes priority over push and pop. On the next edge, `wptr`, `rptr` and `level` are cleared to 0. Any push or pop in the flush cycle is discarded and its handshake is ignored.
- `flush` does not clear `high_water`. Memory contents are never reset.
- `high_water` updates to the next-state `level` whenever that value exceeds the current `high_water`. Its maximum value is `DEPTH`.
- Async reset (`rst_n` = 0), effective immediately:
  - `wptr`, `rptr`, `level`, `high_water` = 0
  - `in_ready` = 1, `out_valid` = 0, `out_data` = 0
  - `almost_empty` = 1
  - `almost_full` = 1 only if `AFULL_LEVEL` == 0, otherwise 0.
- Reset asserted mid-transfer drops all stored words. The first push after `rst_n` deasserts is accepted on the first rising edge at which `rst_n` is high.

## Timing
- Write-to-read latency without bypass is one cycle: a push at edge N gives `out_valid` = 1 after edge N.
- `level`, `almost_full`, `almost_empty` and `high_water` are registered or decoded from registers only. They reflect pushes and pops one cycle after the handshake.
- Sustained throughput is one word per cycle whenever 0 < `level` < `DEPTH`.
- With `DEPTH` = 1, producer and consumer alternate, giving at most one word every two cycles unless bypass is enabled.

## Configuration
- `MYGO_FIFO_BYPASS_EN` defined:
  - When `level` == 0, `in_valid` = 1 and `out_ready` = 1, the word passes straight through in the same cycle: `out_valid` = 1 and `out_data` = `in_data`.
  - The word is not stored. `level`, both pointers and `high_water` are unchanged.
  - A bypass cycle counts as both push and pop for the handshake.
  - `in_ready` is unaffected.
  - `flush` suppresses bypass.
- `MYGO_FIFO_BYPASS_EN` undefined:
  - No combinational path from `in_*` to `out_*`.
  - Minimum latency is one cycle.

## Test plan
- Reset then idle: `rst_n` low mid-cycle → `level` = 0, `in_ready` = 1, `out_valid` = 0, `out_data` = 0, `almost_empty` = 1, all immediately and without waiting for a clock edge.
- Fill and drain with `WIDTH` = 8, `DEPTH` = 5, `out_ready` = 0: push 0x11..0x55 → `in_ready` drops after the 5th push, `level` = 5, `almost_full` = 1 from `level` 4. Then set `out_ready` = 1 → data 0x11..0x55 read in order, and `level` returns to 0.
- Wrap-around with `DEPTH` = 5: 13 words at one push and one pop per cycle, starting at `level` 2 → data order preserved across pointer wrap, `level` constant at 2.
- Full with simultaneous pop: `level` = `DEPTH`, `in_valid` = 1, `out_ready` = 1 → pop accepted, push refused, `level` = `DEPTH`−1 next cycle.
- Flush at `level` 3 with push and pop asserted in the same cycle → next cycle `level` = 0, `out_valid` = 0, `high_water` stays 3.
- Bypass build with `MYGO_FIFO_BYPASS_EN`, empty FIFO: `in_data` = 0xA5, `in_valid` = 1, `out_ready` = 1 → `out_valid` = 1 and `out_data` = 0xA5 in the same cycle, `level` stays 0. Without the macro → `out_valid` rises one cycle later and `level` pulses to 1.

Source files
------------

// File: rtl/mygo_fifo_ex.sv
// Parametrised channel FIFO with flush, occupancy/threshold flags and a high-water monitor.
// Define MYGO_FIFO_BYPASS_EN to let a word pass straight through an empty FIFO in one cycle.
module mygo_fifo_ex #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned AFULL_LEVEL  = DEPTH - 1,
  parameter int unsigned AEMPTY_LEVEL = 1,
  parameter int unsigned ADDR_BITS    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int unsigned COUNT_BITS   = ($clog2(DEPTH + 1) > 1) ? $clog2(DEPTH + 1) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [WIDTH-1:0]      in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [COUNT_BITS-1:0] level,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [COUNT_BITS-1:0] high_water
);

  localparam logic [ADDR_BITS-1:0]  LastPtr   = ADDR_BITS'(DEPTH - 1);
  localparam logic [COUNT_BITS-1:0] FullLevel = COUNT_BITS'(DEPTH);

  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [ADDR_BITS-1:0]  r_wptr;
  logic [ADDR_BITS-1:0]  r_rptr;
  logic [COUNT_BITS-1:0] r_level;
  logic [COUNT_BITS-1:0] r_high_water;

  logic [ADDR_BITS-1:0]  w_wptr_nxt;
  logic [ADDR_BITS-1:0]  w_rptr_nxt;
  logic [COUNT_BITS-1:0] w_level_nxt;
  logic [COUNT_BITS-1:0] w_high_water_nxt;
  logic                  w_nonempty;
  logic                  w_full;
  logic                  w_bypass;
  logic                  w_push_st;
  logic                  w_pop_st;
  logic [WIDTH-1:0]      w_head;

  // Wrap explicitly so non-power-of-two depths stay inside the array.
  function automatic logic [ADDR_BITS-1:0] ptr_inc(input logic [ADDR_BITS-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  assign w_nonempty = (r_level != '0);
  assign w_full     = (r_level == FullLevel);
  assign w_head     = r_mem[r_rptr];
  assign in_ready   = ~w_full;

`ifdef MYGO_FIFO_BYPASS_EN
  assign w_bypass  = ~w_nonempty & in_valid & out_ready & ~flush;
  assign out_valid = w_nonempty | w_bypass;
  assign out_data  = w_nonempty ? w_head : (w_bypass ? in_data : '0);
`else
  assign w_bypass  = 1'b0;
  assign out_valid = w_nonempty;
  assign out_data  = w_nonempty ? w_head : '0;
`endif

  // A bypassed word is consumed in flight and never touches storage.
  assign w_push_st = in_valid & in_ready & ~flush & ~w_bypass;
  assign w_pop_st  = w_nonempty & out_ready & ~flush;

  always_comb begin
    w_wptr_nxt  = r_wptr;
    w_rptr_nxt  = r_rptr;
    w_level_nxt = r_level;
    if (flush) begin
      w_wptr_nxt  = '0;
      w_rptr_nxt  = '0;
      w_level_nxt = '0;
    end else begin
      if (w_push_st) w_wptr_nxt = ptr_inc(r_wptr);
      if (w_pop_st)  w_rptr_nxt = ptr_inc(r_rptr);
      case ({w_push_st, w_pop_st})
        2'b10:   w_level_nxt = r_level + 1'b1;
        2'b01:   w_level_nxt = r_level - 1'b1;
        default: w_level_nxt = r_level;
      endcase
    end
  end

  always_comb begin
    w_high_water_nxt = r_high_water;
    if (w_level_nxt > r_high_water) w_high_water_nxt = w_level_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_level      <= '0;
      r_high_water <= '0;
    end else begin
      r_wptr       <= w_wptr_nxt;
      r_rptr       <= w_rptr_nxt;
      r_level      <= w_level_nxt;
      r_high_water <= w_high_water_nxt;
    end
  end

  // Storage is deliberately left unreset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (w_push_st) r_mem[r_wptr] <= in_data;
  end

  assign level        = r_level;
  assign high_water   = r_high_water;
  assign almost_full  = (32'(r_level) >= AFULL_LEVEL);
  assign almost_empty = (32'(r_level) <= AEMPTY_LEVEL);

endmodule
